// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: writeback source encodings,
// register-zero index, halt FSM states, the pipeline entry layout and the
// writeback data selector.
package mem_wb_stage_pkg;

    // Writeback source select encodings (shared with decode)
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC  = 2'b10;

    // Hard-wired zero register
    localparam logic [3:0] REG_ZERO = 4'd0;

    // Halt FSM states
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    // One MEM/WB pipeline entry
    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memwrite;
        logic        halt;
        logic [1:0]  wb_sel;
        logic [3:0]  dst_reg;
        logic [15:0] alu_val;
        logic [15:0] data_out;
        logic [15:0] pc_plus2;
    } wb_entry_t;

    // Writeback data source; the reserved encoding falls back to the ALU value
    function automatic logic [15:0] wb_mux(
        input logic [1:0]  sel,
        input logic [15:0] alu_val,
        input logic [15:0] data_out,
        input logic [15:0] pc_plus2
    );
        logic [15:0] res;
        case (sel)
            WB_SEL_ALU: res = alu_val;
            WB_SEL_MEM: res = data_out;
            WB_SEL_PC:  res = pc_plus2;
            default:    res = alu_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_wb_stage_sat_counter.sv
// Saturating up-counter: advances by one on each enabled cycle and sticks
// at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: increment when enabled and not yet saturated
    always_comb begin
        q_d = q_q;
        if (en && !(&q_q)) begin
            q_d = q_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q_d = q_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage of the 16-bit pipelined CPU.
// Drives the regfile write port (also used for forwarding), owns the sticky
// halt state and keeps saturating cycle / retired-instruction counters.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic             mem_memwrite,
    input  logic             mem_halt,
    input  logic [1:0]       mem_wb_sel,
    input  logic [3:0]       mem_dst_reg,
    input  logic [15:0]      mem_alu_val,
    input  logic [15:0]      mem_data_out,
    input  logic [15:0]      mem_pc_plus2,
    output logic             wb_regwrite,
    output logic [3:0]       dst_reg,
    output logic [15:0]      dst_data,
    output logic             hlt,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    wb_entry_t  mem_entry;
    wb_entry_t  entry_q;
    wb_entry_t  entry_d;
    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       counted_q;
    logic       counted_d;
    logic       capture;
    logic       counted_pre;
    logic       retire_en;
    logic       cycle_en;

    // Bundle the MEM-stage inputs into one entry
    always_comb begin
        mem_entry.valid    = mem_valid;
        mem_entry.regwrite = mem_regwrite;
        mem_entry.memwrite = mem_memwrite;
        mem_entry.halt     = mem_halt;
        mem_entry.wb_sel   = mem_wb_sel;
        mem_entry.dst_reg  = mem_dst_reg;
        mem_entry.alu_val  = mem_alu_val;
        mem_entry.data_out = mem_data_out;
        mem_entry.pc_plus2 = mem_pc_plus2;
    end

    // Capture policy and halt FSM: flush beats stall; once halted everything freezes
    always_comb begin
        entry_d = entry_q;
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    entry_d = '0;
                    capture = 1'b1;
                    state_d = ST_RUN;
                end else if (!stall) begin
                    entry_d = mem_entry;
                    capture = 1'b1;
                    if (mem_valid && mem_halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    entry_d = entry_q;
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                entry_d = entry_q;
                state_d = ST_HALTED;
            end
            default: begin
                entry_d = entry_q;
                state_d = ST_HALTED;
            end
        endcase
    end

    // Retire accounting: count an entry once as it enters WB, so the count is
    // already visible while that entry is in WB; the counted flag stops a
    // stalled entry from being counted again and is cleared by every capture
    always_comb begin
        if (capture) begin
            counted_pre = 1'b0;
        end else begin
            counted_pre = counted_q;
        end
        retire_en = (state_q == ST_RUN) && !counted_pre && entry_d.valid
                    && (entry_d.regwrite || entry_d.memwrite || entry_d.halt);
        counted_d = counted_pre || retire_en;
        cycle_en  = (state_q == ST_RUN);
    end

    // MEM/WB register, counted flag and FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q   <= '0;
            counted_q <= 1'b0;
            state_q   <= ST_RUN;
        end else begin
            entry_q   <= entry_d;
            counted_q <= counted_d;
            state_q   <= state_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cycle_en),
        .q     (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire_en),
        .q     (retire_count)
    );

    // Writeback port decode: $0 writes and anything after halt are suppressed
    always_comb begin
        wb_regwrite = entry_q.valid && entry_q.regwrite
                      && (entry_q.dst_reg != REG_ZERO) && (state_q == ST_RUN);
        dst_reg     = entry_q.dst_reg;
        dst_data    = wb_mux(entry_q.wb_sel, entry_q.alu_val,
                             entry_q.data_out, entry_q.pc_plus2);
        hlt         = (state_q == ST_HALTED);
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed vector table, hand-written halt /
// reset sequences, randomized traffic against a reference model, and a
// narrow-counter instance for saturation.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n, rst4_n;
    logic        stall, flush, mv, mrw, mmw, mhalt;
    logic [1:0]  msel;
    logic [3:0]  mdst;
    logic [15:0] malu, mdout, mpc;

    logic        wb_regwrite, hlt;
    logic [3:0]  dst_reg;
    logic [15:0] dst_data;
    logic [31:0] cycle_count, retire_count;

    logic        wr4, hlt4;
    logic [3:0]  dst4;
    logic [15:0] data4;
    logic [3:0]  cyc4, ret4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mv), .mem_regwrite(mrw), .mem_memwrite(mmw), .mem_halt(mhalt),
        .mem_wb_sel(msel), .mem_dst_reg(mdst), .mem_alu_val(malu),
        .mem_data_out(mdout), .mem_pc_plus2(mpc),
        .wb_regwrite(wb_regwrite), .dst_reg(dst_reg), .dst_data(dst_data),
        .hlt(hlt), .cycle_count(cycle_count), .retire_count(retire_count)
    );

    // Narrow-counter instance that never halts, used to reach saturation
    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .stall(stall), .flush(flush),
        .mem_valid(mv), .mem_regwrite(mrw), .mem_memwrite(mmw), .mem_halt(1'b0),
        .mem_wb_sel(msel), .mem_dst_reg(mdst), .mem_alu_val(malu),
        .mem_data_out(mdout), .mem_pc_plus2(mpc),
        .wb_regwrite(wr4), .dst_reg(dst4), .dst_data(data4),
        .hlt(hlt4), .cycle_count(cyc4), .retire_count(ret4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        stall, flush, valid, rw, mw, halt;
        logic [1:0]  sel;
        logic [3:0]  dst;
        logic [15:0] alu, dout, pc;
        logic        e_wr;
        logic [3:0]  e_dst;
        logic [15:0] e_data;
        logic [31:0] e_ret;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(
        input logic s, f, v, rw, mw, h, input logic [1:0] sel, input logic [3:0] dst,
        input logic [15:0] alu, dout, pc,
        input logic e_wr, input logic [3:0] e_dst, input logic [15:0] e_data,
        input logic [31:0] e_ret);
        vec_t r;
        r.stall = s; r.flush = f; r.valid = v; r.rw = rw; r.mw = mw; r.halt = h;
        r.sel = sel; r.dst = dst; r.alu = alu; r.dout = dout; r.pc = pc;
        r.e_wr = e_wr; r.e_dst = e_dst; r.e_data = e_data; r.e_ret = e_ret;
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v, rw, mw, h;
        logic [1:0]  sel;
        logic [3:0]  dst;
        logic [15:0] alu, dout, pc;
    } ent_t;

    ent_t        m_ent;
    bit          m_halted;
    longint      m_cyc, m_ret;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

    function automatic longint sat_inc(input longint x);
        return (x >= MAX32) ? MAX32 : x + 64'd1;
    endfunction

    task automatic model_reset();
        m_ent = '0; m_halted = 1'b0; m_cyc = 0; m_ret = 0;
    endtask

    // One clock edge of the architectural rules
    task automatic model_edge();
        if (!m_halted) begin
            m_cyc = sat_inc(m_cyc);
            if (flush) begin
                m_ent = '0;
            end else if (!stall) begin
                m_ent.v = mv; m_ent.rw = mrw; m_ent.mw = mmw; m_ent.h = mhalt;
                m_ent.sel = msel; m_ent.dst = mdst;
                m_ent.alu = malu; m_ent.dout = mdout; m_ent.pc = mpc;
                if (mv && (mrw || mmw || mhalt)) m_ret = sat_inc(m_ret);
                if (mv && mhalt) m_halted = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] ed;
        case (m_ent.sel)
            2'd1:    ed = m_ent.dout;
            2'd2:    ed = m_ent.pc;
            default: ed = m_ent.alu;
        endcase
        chk({tag, ".wb_regwrite"}, {31'd0, wb_regwrite},
            {31'd0, m_ent.v && m_ent.rw && (m_ent.dst != 4'd0) && !m_halted});
        chk({tag, ".dst_reg"}, {28'd0, dst_reg}, {28'd0, m_ent.dst});
        chk({tag, ".dst_data"}, {16'd0, dst_data}, {16'd0, ed});
        chk({tag, ".hlt"}, {31'd0, hlt}, {31'd0, m_halted});
        chk({tag, ".cycle_count"}, cycle_count, m_cyc[31:0]);
        chk({tag, ".retire_count"}, retire_count, m_ret[31:0]);
    endtask

    task automatic set_in(input logic s, f, v, rw, mw, h, input logic [1:0] sel,
                          input logic [3:0] dst, input logic [15:0] alu, dout, pc);
        stall = s; flush = f; mv = v; mrw = rw; mmw = mw; mhalt = h;
        msel = sel; mdst = dst; malu = alu; mdout = dout; mpc = pc;
    endtask

    task automatic tick(input bit use_model);
        @(posedge clk);
        if (use_model) model_edge();
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wb_regwrite"}, {31'd0, wb_regwrite}, 32'd0);
        chk({tag, ".dst_reg"}, {28'd0, dst_reg}, 32'd0);
        chk({tag, ".dst_data"}, {16'd0, dst_data}, 32'd0);
        chk({tag, ".hlt"}, {31'd0, hlt}, 32'd0);
        chk({tag, ".cycle_count"}, cycle_count, 32'd0);
        chk({tag, ".retire_count"}, retire_count, 32'd0);
    endtask

    initial begin
        // vector table: inputs, then expected wb_regwrite / dst_reg / dst_data / retire_count
        tbl[0]  = mk(0,0,1,1,0,0, 2'b00, 4'd3, 16'h1234, 16'h0000, 16'h0000, 1, 4'd3, 16'h1234, 32'd1);
        tbl[1]  = mk(0,0,1,1,0,0, 2'b01, 4'd5, 16'h1111, 16'hBEEF, 16'h0002, 1, 4'd5, 16'hBEEF, 32'd2);
        tbl[2]  = mk(0,0,1,1,0,0, 2'b10, 4'd7, 16'h2222, 16'h3333, 16'h0042, 1, 4'd7, 16'h0042, 32'd3);
        tbl[3]  = mk(0,0,1,1,0,0, 2'b00, 4'd0, 16'hFFFF, 16'h0000, 16'h0000, 0, 4'd0, 16'hFFFF, 32'd4);
        tbl[4]  = mk(0,0,1,0,1,0, 2'b00, 4'd1, 16'h0100, 16'h0000, 16'h0000, 0, 4'd1, 16'h0100, 32'd5);
        tbl[5]  = mk(0,0,1,1,0,0, 2'b11, 4'd2, 16'h2222, 16'h3333, 16'h4444, 1, 4'd2, 16'h2222, 32'd6);
        tbl[6]  = mk(1,0,1,1,0,0, 2'b00, 4'd9, 16'h9999, 16'h0000, 16'h0000, 1, 4'd2, 16'h2222, 32'd6);
        tbl[7]  = mk(1,0,1,1,0,0, 2'b01, 4'd8, 16'h8888, 16'h0000, 16'h0000, 1, 4'd2, 16'h2222, 32'd6);
        tbl[8]  = mk(1,0,1,0,1,0, 2'b00, 4'd9, 16'h7777, 16'h0000, 16'h0000, 1, 4'd2, 16'h2222, 32'd6);
        tbl[9]  = mk(1,1,1,1,0,0, 2'b00, 4'd9, 16'h9999, 16'h0000, 16'h0000, 0, 4'd0, 16'h0000, 32'd6);
        tbl[10] = mk(0,0,0,1,0,0, 2'b00, 4'd4, 16'h5555, 16'h0000, 16'h0000, 0, 4'd4, 16'h5555, 32'd6);
        tbl[11] = mk(0,0,1,1,0,0, 2'b00, 4'd4, 16'h5A5A, 16'h0000, 16'h0000, 1, 4'd4, 16'h5A5A, 32'd7);

        // reset state
        rst_n = 1'b0; rst4_n = 1'b0;
        set_in(0,0,0,0,0,0, 2'b00, 4'd0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1; rst4_n = 1'b1;

        // directed table
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].stall, tbl[i].flush, tbl[i].valid, tbl[i].rw, tbl[i].mw, tbl[i].halt,
                   tbl[i].sel, tbl[i].dst, tbl[i].alu, tbl[i].dout, tbl[i].pc);
            tick(0);
            chk($sformatf("vec%0d.wb_regwrite", i), {31'd0, wb_regwrite}, {31'd0, tbl[i].e_wr});
            chk($sformatf("vec%0d.dst_reg", i), {28'd0, dst_reg}, {28'd0, tbl[i].e_dst});
            chk($sformatf("vec%0d.dst_data", i), {16'd0, dst_data}, {16'd0, tbl[i].e_data});
            chk($sformatf("vec%0d.hlt", i), {31'd0, hlt}, 32'd0);
            chk($sformatf("vec%0d.cycle_count", i), cycle_count, i + 1);
            chk($sformatf("vec%0d.retire_count", i), retire_count, tbl[i].e_ret);
        end
        chk("cnt4.cycle_mid", {28'd0, cyc4}, 32'd12);
        chk("cnt4.retire_mid", {28'd0, ret4}, 32'd7);

        // HLT under flush is discarded
        set_in(0,1,1,1,0,1, 2'b00, 4'd6, 16'h6666, 16'h0, 16'h0);
        tick(0);
        chk("flushhlt.hlt", {31'd0, hlt}, 32'd0);
        chk("flushhlt.retire", retire_count, 32'd7);
        chk("flushhlt.wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("flushhlt.cycle", cycle_count, 32'd13);

        // real HLT (with regwrite set) reaches WB
        set_in(0,0,1,1,0,1, 2'b00, 4'd6, 16'h6666, 16'h0, 16'h0);
        tick(0);
        chk("hlt.hlt", {31'd0, hlt}, 32'd1);
        chk("hlt.wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("hlt.retire", retire_count, 32'd8);
        chk("hlt.cycle", cycle_count, 32'd14);
        chk("hlt.dst_data", {16'd0, dst_data}, 32'h6666);

        // further traffic is ignored while halted
        for (int i = 0; i < 3; i++) begin
            set_in(0, i[0], 1,1,0,0, 2'b00, 4'd3, 16'h7777, 16'h0, 16'h0);
            tick(0);
            chk($sformatf("halted%0d.hlt", i), {31'd0, hlt}, 32'd1);
            chk($sformatf("halted%0d.wb_regwrite", i), {31'd0, wb_regwrite}, 32'd0);
            chk($sformatf("halted%0d.retire", i), retire_count, 32'd8);
            chk($sformatf("halted%0d.cycle", i), cycle_count, 32'd14);
            chk($sformatf("halted%0d.dst_reg", i), {28'd0, dst_reg}, 32'd6);
        end

        // mid-cycle reset clears halt and counters immediately
        #3 rst_n = 1'b0;
        #1 chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model, each segment starts with a mid-cycle reset
        for (int seg = 0; seg < 4; seg++) begin
            @(posedge clk);
            #3 rst_n = 1'b0;
            model_reset();
            #1 check_model($sformatf("rst%0d", seg));
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 120; c++) begin
                set_in(($urandom % 5) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                       $urandom % 2, $urandom % 2, ($urandom % 40) == 0,
                       2'($urandom % 4), 4'($urandom % 16),
                       16'($urandom), 16'($urandom), 16'($urandom));
                tick(1);
                check_model($sformatf("rnd%0d_%0d", seg, c));
                #3;
            end
        end

        // narrow instance has run far past 15 cycles / 15 retirements
        chk("cnt4.cycle_sat", {28'd0, cyc4}, 32'hF);
        chk("cnt4.retire_sat", {28'd0, ret4}, 32'hF);
        chk("cnt4.hlt", {31'd0, hlt4}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback stage of the 16-bit pipelined cpu.
- Captures MEM-stage results, selects the register writeback source, and drives regfile write signals (WB_RegWrite, dst_reg, dst_data), also used for forwarding.
- Owns the sticky halt state (hlt) and hardware retire/cycle counters whose semantics match the bench statistics.

Parameters:
- CNT_W, 32, width of cycle and retire counters (saturating).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold MEM/WB register contents this cycle
- flush  in  1  load a bubble instead of MEM-stage values
- mem_valid  in  1  MEM stage holds a real instruction
- mem_regwrite  in  1  instruction writes a register
- mem_memwrite  in  1  instruction is a store (retire counting only)
- mem_halt  in  1  instruction is HLT
- mem_wb_sel  in  2  writeback source select
- mem_dst_reg  in  4  destination register
- mem_alu_val  in  16  ALU result / memory address
- mem_data_out  in  16  data read from data memory
- mem_pc_plus2  in  16  PC+2 of instruction (for PCS)
- wb_regwrite  out  1  regfile write enable
- dst_reg  out  4  regfile write address
- dst_data  out  16  regfile write data
- hlt  out  1  halt reached writeback; sticky
- cycle_count  out  CNT_W  cycles since reset release
- retire_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n=0): all register contents cleared, valid=0, state=RUN. Outputs wb_regwrite=0, dst_reg=0, dst_data=0, hlt=0, cycle_count=0, retire_count=0. Reset mid-operation discards the WB entry immediately.
- Capture on posedge: flush=1 loads a bubble (valid=0, all controls 0); else stall=1 holds; else loads mem_* values. Flush wins over stall. WB outputs reflect the captured entry in the cycle after capture (1-cycle latency).
- dst_data is combinational from registered fields:
  - wb_sel 00 → alu_val
  - wb_sel 01 → data_out
  - wb_sel 10 → pc_plus2
  - wb_sel 11 → reserved, treated as alu_val
- wb_regwrite = valid & regwrite & (dst_reg != 0) & state==RUN. Writes to $0 are suppressed. dst_reg and dst_data are driven regardless.
- Stall holding a writing entry keeps wb_regwrite asserted every cycle; this is an idempotent rewrite.
- Retire counting:
  - retire_count increments once per entry: valid & (regwrite | memwrite | halt), in the first cycle the entry is in WB.
  - A "counted" flag, set on that cycle and cleared on each new capture, blocks recounting during stall.
  - A suppressed $0 write still counts.
- cycle_count increments every cycle in RUN after reset release. Both counters saturate at all-ones.
- Halt FSM, states RUN and HALTED:
  - RUN→HALTED on the posedge that captures a valid entry with halt=1 (not flushed). hlt asserts in the same cycle the HLT entry appears in WB.
  - HALT entry never writes a register, even if mem_regwrite=1.
  - HALTED: register frozen, stall/flush/mem_* ignored, wb_regwrite=0, counters frozen, hlt=1 until reset.
  - HLT is counted in retire_count exactly once.
- A HLT presented with flush=1 is discarded; the FSM stays in RUN.

Decomposition:
- Shared include cpu_defs.vh, also used by decode: WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC=2'b10, plus REG_ZERO=4'd0.
- Sub-module sat_counter (param W; ports clk, rst_n, en, q), instantiated twice for cycle_count and retire_count.
- Mux, MEM/WB register and FSM stay in mem_wb_stage.

Test Plan:
- Reset release, then mem_valid=1, regwrite=1, wb_sel=00, dst_reg=3, alu_val=16'h1234 for one cycle → next cycle wb_regwrite=1, dst_reg=3, dst_data=16'h1234, retire_count=1.
- LW: wb_sel=01, data_out=16'hBEEF, dst_reg=5; then PCS: wb_sel=10, pc_plus2=16'h0042, dst_reg=7 → dst_data=BEEF then 0042 on consecutive cycles, retire_count +2.
- Write to dst_reg=0 with alu_val=16'hFFFF → wb_regwrite=0, retire_count still +1; store (memwrite=1, regwrite=0) → retire_count +1, wb_regwrite=0.
- Load dst_reg=2, then stall=1 for 3 cycles → outputs held, wb_regwrite=1 all 4 cycles, retire_count +1 only. Stall=1 with flush=1 → bubble, wb_regwrite=0.
- HLT with mem_regwrite=1, followed by further valid writes → hlt=1 the cycle HLT is in WB, wb_regwrite=0 from then on, counters frozen (retire counts HLT once), hlt stays 1. Assert rst_n=0 mid-cycle → hlt=0 and counters=0 immediately.
- HLT presented with flush=1 → hlt stays 0, retire_count unchanged. Force cycle_count near all-ones (CNT_W=4 build) → saturates at 4'hF.
